cdr_phase_gen: RTL
==================

# cdr_phase_gen

Transmit-side counterpart of the CDR. It serializes data bits into a stream of signed 6-bit phase samples: each bit is rendered as `SAMPLES_PER_BIT` phase steps, `+STEP` for a 1 and `-STEP` for a 0. One phase LSB is 5.625°, and the accumulator wraps modulo 64. It sits between the TX bit source (FIFO TX serial output) and the phase-to-IQ stage. Its output must decode correctly through the existing CDR.

## Interface
Parameters:
- `SAMPLES_PER_BIT`, default 5: phase samples per bit, legal range 2..15.
- `STEP`, default 4: phase increment magnitude in LSBs, legal range 1..31.

Ports:
- `clk_i`  in  1  system clock.
- `resetn_i`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  run enable. Deasserting it lets the current bit finish, then the block idles.
- `data_i`  in  1  bit to transmit.
- `data_valid_i`  in  1  `data_i` is valid.
- `data_ready_o`  out  1  block can accept a bit this cycle.
- `tick_i`  in  1  sample strobe (DAC ready); one phase step per tick.
- `phase_o`  out  6  signed phase sample, two's complement.
- `phase_valid_o`  out  1  `phase_o` updated this cycle.
- `busy_o`  out  1  a bit is in flight (state RUN).
- `underrun_o`  out  1  one-cycle pulse: a bit ended with `enable_i`=1 and no next bit buffered.

## Operation
Registers:
- 1-entry bit buffer (`buf_bit`, `buf_full`).
- Current bit `cur_bit`.
- Sample counter `cnt`, 4 bits.
- Phase accumulator `phase`, 6 bits.

Handshake:
- `data_ready_o` = `enable_i` & ~`buf_full`. This is combinational from registers and `enable_i`.
- Transfer occurs on a clock edge where `data_valid_i` & `data_ready_o`. It sets `buf_full`=1 and `buf_bit`=`data_i`.

State IDLE:
- Entered after reset.
- If `buf_full`: move the buffer into `cur_bit`, clear `buf_full`, set `cnt`=0, go to RUN.
- `phase` holds its value; it is not re-zeroed.

State RUN, on each cycle with `tick_i`=1:
- `phase` ← `phase` + (`cur_bit` ? `STEP` : −`STEP`), mod 64.
- `cnt` ← `cnt`+1.

Bit end is a tick with `cnt`=`SAMPLES_PER_BIT`−1:
- If `buf_full`: load the next bit, clear `buf_full`, set `cnt`=0, stay in RUN. Back-to-back bits produce no gap sample.
- Else if `enable_i`=1: pulse `underrun_o`, go to IDLE.
- Else: go to IDLE silently.

Other rules:
- `tick_i` in IDLE is ignored: no phase change and no `phase_valid_o`.
- `enable_i` low in RUN does not abort. The bit completes, and any already-buffered bit is still sent. New bits are refused because `data_ready_o`=0.
- Buffer freed and new transfer in the same cycle: not possible. At the bit-end edge `buf_full` is still 1, so the next transfer happens at the earliest on the following edge.
- Arithmetic: `STEP` is zero-extended to 6 bits and negated in two's complement. Overflow wraps: +31+1 → −32 and −32−1 → +31.

## Timing
Reset values: `phase_o`=0, `phase_valid_o`=0, `data_ready_o`=`enable_i`, `busy_o`=0, `underrun_o`=0. All state returns to IDLE with `buf_full`=0, `cnt`=0.

Output timing:
- `phase_o` and `phase_valid_o` are registered. Both update on the edge that samples `tick_i`=1 in RUN. `phase_valid_o` is high for exactly that one cycle.

Latency:
- Bit accepted at edge N → IDLE→RUN at edge N+1.
- The first tick sampled at edge ≥ N+2 produces the first step.

Other timing rules:
- `busy_o` is high from the IDLE→RUN edge until the edge that returns to IDLE.
- `underrun_o` is registered and asserts on the same edge as the RUN→IDLE transition.
- Reset asserted mid-bit: all outputs go to their reset values immediately (asynchronous). A buffered bit is discarded.

## Test plan
1. Reset: hold `resetn_i`=0 with ticks and valid data toggling → `phase_o`=0, `phase_valid_o`=0, `busy_o`=0. After release with `enable_i`=1, `data_ready_o`=1.
2. Single 1 bit, tick every 5 cycles, default parameters → `phase_o` = 4, 8, 12, 16, 20 with one `phase_valid_o` per tick. Then `underrun_o` pulses once, `busy_o` falls, and `phase_o` holds 20.
3. Bits 0 then 1, both buffered early, tick every cycle → `phase_o` = −4, −8, −12, −16, −20, −16, −12, −8, −4, 0 with no gap. `data_ready_o` reasserts one cycle after each bit load.
4. Wrap: eight consecutive 1 bits from 0 → after sample 8 `phase_o`=32, which reads as −32 (6'b100000). Sample 9 gives −28 and the final value is 160 mod 64 = 32, i.e. −32. Feeding these samples to the existing CDR returns all 1s.
5. `enable_i` dropped at sample 2 of a 1 bit with a 0 bit buffered → both bits complete (20 then back to 0), `data_ready_o`=0 throughout, no `underrun_o` pulse, then IDLE.
6. `resetn_i` pulsed low at sample 3 of a bit → outputs reset within the same cycle. Afterwards a new 1 bit restarts from `phase_o`=0 and produces 4, 8, ….

Source files
------------

// File: rtl/cdr_phase_gen.sv
// Serializes bits into signed 6-bit phase samples, +/-STEP per tick for SAMPLES_PER_BIT ticks per bit.
// Phase output is registered on the tick edge; a 1-entry buffer is refilled only when data_ready_o is high.
module cdr_phase_gen #(
    parameter int SAMPLES_PER_BIT = 5,
    parameter int STEP            = 4
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       enable_i,
    input  logic       data_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    input  logic       tick_i,
    output logic [5:0] phase_o,
    output logic       phase_valid_o,
    output logic       busy_o,
    output logic       underrun_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SAMPLES_PER_BIT - 1);
    localparam logic [5:0] STEP_POS = 6'(STEP);
    localparam logic [5:0] STEP_NEG = ~STEP_POS + 6'd1;

    state_t     state_q, state_d;
    logic       buf_bit_q, buf_bit_d;
    logic       buf_full_q, buf_full_d;
    logic       cur_bit_q, cur_bit_d;
    logic [3:0] cnt_q, cnt_d;
    logic [5:0] phase_q, phase_d;
    logic       phase_vld_q, phase_vld_d;
    logic       underrun_q, underrun_d;

    assign data_ready_o  = enable_i & ~buf_full_q;
    assign phase_o       = phase_q;
    assign phase_valid_o = phase_vld_q;
    assign busy_o        = (state_q == RUN);
    assign underrun_o    = underrun_q;

    always_comb begin
        state_d     = state_q;
        buf_bit_d   = buf_bit_q;
        buf_full_d  = buf_full_q;
        cur_bit_d   = cur_bit_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        phase_vld_d = 1'b0;
        underrun_d  = 1'b0;

        // A transfer needs buf_full_q=0 and a load needs buf_full_q=1, so they never collide.
        if (data_valid_i && data_ready_o) begin
            buf_full_d = 1'b1;
            buf_bit_d  = data_i;
        end

        case (state_q)
            IDLE: begin
                if (buf_full_q) begin
                    cur_bit_d  = buf_bit_q;
                    buf_full_d = 1'b0;
                    cnt_d      = 4'd0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (tick_i) begin
                    phase_d     = phase_q + (cur_bit_q ? STEP_POS : STEP_NEG);
                    phase_vld_d = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        if (buf_full_q) begin
                            cur_bit_d  = buf_bit_q;
                            buf_full_d = 1'b0;
                            cnt_d      = 4'd0;
                        end else begin
                            state_d    = IDLE;
                            underrun_d = enable_i;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            buf_bit_q   <= 1'b0;
            buf_full_q  <= 1'b0;
            cur_bit_q   <= 1'b0;
            cnt_q       <= 4'd0;
            phase_q     <= 6'd0;
            phase_vld_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_bit_q   <= buf_bit_d;
            buf_full_q  <= buf_full_d;
            cur_bit_q   <= cur_bit_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule
